// File: rtl/cpu_bus_decoder_if.sv
// Bus bundle between the CPU core, the decoder, and the PPU/cartridge targets.
// Modport slave is the decoder's view; master is the CPU/target side.
interface cpu_bus_decoder_if;
  logic [15:0] address_i;
  logic        address_valid_i;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic [2:0]  ppu_address_o;
  logic [7:0]  ppu_data_o;
  logic        ppu_write_o;
  logic        ppu_request_o;
  logic [7:0]  ppu_data_i;
  logic        ppu_ack_i;
  logic [15:0] cart_address_o;
  logic [7:0]  cart_data_o;
  logic        cart_write_o;
  logic        cart_request_o;
  logic [7:0]  cart_data_i;
  logic        cart_ack_i;

  modport slave (
    input  address_i, address_valid_i, data_i, data_valid_i,
    output data_o, data_valid_o,
    output ppu_address_o, ppu_data_o, ppu_write_o, ppu_request_o,
    input  ppu_data_i, ppu_ack_i,
    output cart_address_o, cart_data_o, cart_write_o, cart_request_o,
    input  cart_data_i, cart_ack_i
  );

  modport master (
    output address_i, address_valid_i, data_i, data_valid_i,
    input  data_o, data_valid_o,
    input  ppu_address_o, ppu_data_o, ppu_write_o, ppu_request_o,
    output ppu_data_i, ppu_ack_i,
    input  cart_address_o, cart_data_o, cart_write_o, cart_request_o,
    output cart_data_i, cart_ack_i
  );
endinterface

// File: rtl/cpu_bus_decoder.sv
// CPU bus decoder: mirrored 2 KiB work RAM, PPU/cartridge request-ack ports, open-bus reads.
// Optional macro CPU_BUS_TIMEOUT_EN bounds the wait for a target acknowledge.
module cpu_bus_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic             clock_i,
  input  logic             reset_i,
  cpu_bus_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RAM_READ, WAIT_TARGET, DONE} state_e;
  typedef enum logic [1:0] {REG_RAM, REG_PPU, REG_NONE, REG_CART} region_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  open_bus_q, open_bus_d;
  logic        ppu_req_q, ppu_req_d;
  logic        ppu_write_q, ppu_write_d;
  logic [2:0]  ppu_addr_q, ppu_addr_d;
  logic [7:0]  ppu_wdata_q, ppu_wdata_d;
  logic        cart_req_q, cart_req_d;
  logic        cart_write_q, cart_write_d;
  logic [15:0] cart_addr_q, cart_addr_d;
  logic [7:0]  cart_wdata_q, cart_wdata_d;
  logic [7:0]  ram_rdata_q, ram_rdata_d;
  logic        ram_we;
  logic        key_match;
  logic        tgt_ack;
  logic [7:0]  tgt_rdata;
  logic [7:0]  done_data;
  logic [7:0]  mem [2048];
`ifdef CPU_BUS_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
`endif

  function automatic region_e decode(input logic [15:0] a);
    if (a[15:13] == 3'd0) return REG_RAM;
    if (a[15:13] == 3'd1) return REG_PPU;
    if (a < 16'h4020) return REG_NONE;
    return REG_CART;
  endfunction

  // The key covers write data too, so a changed byte on a held address is a new transaction.
  assign key_match = (bus.address_i == addr_q) && (bus.data_valid_i == wr_q) &&
                     (bus.data_i == wdata_q);
  assign tgt_ack   = ppu_req_q ? bus.ppu_ack_i  : bus.cart_ack_i;
  assign tgt_rdata = ppu_req_q ? bus.ppu_data_i : bus.cart_data_i;
  assign ram_rdata_d = mem[bus.address_i[10:0]];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    open_bus_d   = open_bus_q;
    ppu_req_d    = ppu_req_q;
    ppu_write_d  = ppu_write_q;
    ppu_addr_d   = ppu_addr_q;
    ppu_wdata_d  = ppu_wdata_q;
    cart_req_d   = cart_req_q;
    cart_write_d = cart_write_q;
    cart_addr_d  = cart_addr_q;
    cart_wdata_d = cart_wdata_q;
    ram_we       = 1'b0;
    done_data    = wr_q ? wdata_q : tgt_rdata;
`ifdef CPU_BUS_TIMEOUT_EN
    tmo_d        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.address_valid_i) begin
          addr_d  = bus.address_i;
          wr_d    = bus.data_valid_i;
          wdata_d = bus.data_i;
          case (decode(bus.address_i))
            REG_RAM: begin
              if (bus.data_valid_i) begin
                ram_we     = 1'b1;
                data_d     = bus.data_i;
                open_bus_d = bus.data_i;
                state_d    = DONE;
              end else begin
                state_d = RAM_READ;
              end
            end
            REG_NONE: begin
              data_d     = bus.data_valid_i ? bus.data_i : open_bus_q;
              open_bus_d = bus.data_valid_i ? bus.data_i : open_bus_q;
              state_d    = DONE;
            end
            REG_PPU: begin
              ppu_req_d   = 1'b1;
              ppu_addr_d  = bus.address_i[2:0];
              ppu_write_d = bus.data_valid_i;
              ppu_wdata_d = bus.data_i;
              state_d     = WAIT_TARGET;
            end
            default: begin
              cart_req_d   = 1'b1;
              cart_addr_d  = bus.address_i;
              cart_write_d = bus.data_valid_i;
              cart_wdata_d = bus.data_i;
              state_d      = WAIT_TARGET;
            end
          endcase
        end
      end
      RAM_READ: begin
        if (bus.address_valid_i && key_match) begin
          data_d     = ram_rdata_q;
          open_bus_d = ram_rdata_q;
          state_d    = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_TARGET: begin
        // The request stays up until ack even if the CPU moved on; a stale result is dropped.
        if (tgt_ack) begin
          ppu_req_d  = 1'b0;
          cart_req_d = 1'b0;
          if (bus.address_valid_i && key_match) begin
            data_d     = done_data;
            open_bus_d = done_data;
            state_d    = DONE;
          end else begin
            state_d = IDLE;
          end
`ifdef CPU_BUS_TIMEOUT_EN
        end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
          ppu_req_d  = 1'b0;
          cart_req_d = 1'b0;
          if (bus.address_valid_i && key_match) begin
            data_d     = wr_q ? wdata_q : open_bus_q;
            open_bus_d = wr_q ? wdata_q : open_bus_q;
            state_d    = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
`endif
        end
      end
      default: begin
        if (!(bus.address_valid_i && key_match)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      data_q       <= '0;
      open_bus_q   <= '0;
      ppu_req_q    <= 1'b0;
      ppu_write_q  <= 1'b0;
      ppu_addr_q   <= '0;
      ppu_wdata_q  <= '0;
      cart_req_q   <= 1'b0;
      cart_write_q <= 1'b0;
      cart_addr_q  <= '0;
      cart_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      open_bus_q   <= open_bus_d;
      ppu_req_q    <= ppu_req_d;
      ppu_write_q  <= ppu_write_d;
      ppu_addr_q   <= ppu_addr_d;
      ppu_wdata_q  <= ppu_wdata_d;
      cart_req_q   <= cart_req_d;
      cart_write_q <= cart_write_d;
      cart_addr_q  <= cart_addr_d;
      cart_wdata_q <= cart_wdata_d;
    end
  end

`ifdef CPU_BUS_TIMEOUT_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif

  // Work RAM keeps its contents across reset.
  always_ff @(posedge clock_i) begin
    if (ram_we) mem[bus.address_i[10:0]] <= bus.data_i;
    ram_rdata_q <= ram_rdata_d;
  end

  assign bus.data_o         = data_q;
  assign bus.data_valid_o   = (state_q == DONE) && bus.address_valid_i && key_match;
  assign bus.ppu_address_o  = ppu_addr_q;
  assign bus.ppu_data_o     = ppu_wdata_q;
  assign bus.ppu_write_o    = ppu_write_q;
  assign bus.ppu_request_o  = ppu_req_q & ~reset_i;
  assign bus.cart_address_o = cart_addr_q;
  assign bus.cart_data_o    = cart_wdata_q;
  assign bus.cart_write_o   = cart_write_q;
  assign bus.cart_request_o = cart_req_q & ~reset_i;
endmodule

// File: doc/cpu_bus_decoder.md
# cpu_bus_decoder

Memory-side bus stage directly downstream of the CPU core. It decodes the CPU's 16-bit address/valid request, serves the 2 KiB internal work RAM (mirrored), and forwards PPU-register and cartridge accesses over request/acknowledge ports. It returns read data with a qualified valid flag the CPU can sample on any of its divided clock ticks. Unmapped or unresponsive targets return the open-bus byte.

## Interface
- `TIMEOUT_CYCLES`, 15: maximum cycles spent waiting for `ppu_ack_i`/`cart_ack_i` (only with `CPU_BUS_TIMEOUT_EN`).
- `clock_i` in 1: sole clock.
- `reset_i` in 1: reset, synchronous and active-high.
- `address_i` in 16: CPU address.
- `address_valid_i` in 1: CPU address is valid.
- `data_i` in 8: CPU write data.
- `data_valid_i` in 1: write strobe; 1 = write, 0 = read.
- `data_o` out 8: read data / open-bus byte to CPU.
- `data_valid_o` out 1: `data_o` is valid for the currently presented request.
- `ppu_address_o` out 3: PPU register index.
- `ppu_data_o` out 8, `ppu_write_o` out 1, `ppu_request_o` out 1: PPU access request.
- `ppu_data_i` in 8, `ppu_ack_i` in 1: PPU response.
- `cart_address_o` out 16, `cart_data_o` out 8, `cart_write_o` out 1, `cart_request_o` out 1: cartridge access request.
- `cart_data_i` in 8, `cart_ack_i` in 1: cartridge response.

## Operation
- Decode:
  - `$0000-$1FFF`: RAM, index `address[10:0]` (4× mirror).
  - `$2000-$3FFF`: PPU, `ppu_address_o = address[2:0]`.
  - `$4000-$401F`: unmapped. Reads return open bus; writes are dropped.
  - `$4020-$FFFF`: cartridge, full address passed through.
- Transaction key: {`address_i`, `data_valid_i`, `data_i`}, latched when a transaction starts.
  - A transaction ends when `address_valid_i` falls or any key field differs from the latched value.
  - Each transaction performs exactly one access. The CPU holding a request steady does not cause re-access.
- FSM states:
  - IDLE, when `address_valid_i`=1: latch the key, then by region:
    - RAM read → RAM_READ.
    - RAM write: write the RAM → DONE.
    - Unmapped → DONE.
    - PPU/cart → WAIT_TARGET.
  - RAM_READ: capture synchronous RAM data → DONE. If the key changes, go to IDLE instead.
  - WAIT_TARGET: hold the matching `*_request_o`=1 with stable address, data and write outputs.
    - On ack: capture `*_data_i` on reads, drop the request, → DONE.
    - The request is never withdrawn early. If the key changed meanwhile, discard the result and go to IDLE.
  - DONE: hold `data_o`. Go to IDLE when the transaction ends.
- `data_valid_o` = (state==DONE) & `address_valid_i` & (key == latched key). It is gated combinationally, so a stale valid is never visible for a new address.
- Open-bus register: updated with every completed read datum and every write datum. Reads of unmapped space or timed-out reads return it.
- On write completion, `data_o` shows the written byte.
- Only one of `ppu_request_o`/`cart_request_o` is ever high.

## Timing
- Reset values:
  - `data_o`=0, `data_valid_o`=0.
  - All `*_request_o`, `*_write_o`=0.
  - `ppu_address_o`=0, `cart_address_o`=0, `*_data_o`=0.
  - Open bus = 0x00, state IDLE, timeout counter 0.
  - RAM contents are not cleared.
- Reset mid-transaction: return to IDLE next edge; requests drop immediately. The external target must tolerate this.
- Latency, counting cycle 0 as the IDLE cycle in which the request is presented:
  - RAM read: `data_valid_o` in cycle 2.
  - RAM write or unmapped access: `data_valid_o` in cycle 1.
  - PPU/cart: request high from cycle 1; ack sampled in cycle k gives `data_valid_o` in cycle k+1. Zero-wait ack (k=1) is legal.
- Back-to-back: a new key seen in DONE returns to IDLE next edge. Minimum RAM read throughput is one per 3 cycles.
- Ack arriving while not in WAIT_TARGET is ignored.

## Configuration
- `CPU_BUS_TIMEOUT_EN`
  - Defined: an 8-bit counter runs in WAIT_TARGET. After `TIMEOUT_CYCLES` cycles without ack, drop the request and go to DONE with `data_o` = open bus. A write is treated as lost, and open bus still takes the write byte.
  - Undefined: WAIT_TARGET waits indefinitely for ack; the `TIMEOUT_CYCLES` parameter is unused.

## Test plan
- Write 0x5A to `$0001`, then read `$0801` and `$1801`: each read returns 0x5A with `data_valid_o` in cycle 2; a single write is performed.
- Read `$8000` with cart acking after 3 cycles with 0xC3: `cart_request_o` high cycles 1-3, `cart_address_o`=`$8000`, `data_o`=0xC3 valid in cycle 4.
- Write 0x80 to `$2008`: `ppu_address_o`=0, `ppu_write_o`=1, `ppu_data_o`=0x80. Holding the request steady after ack yields no second request.
- After reading 0x3C from RAM, read `$4018`: `data_o`=0x3C valid in cycle 1; no port requests.
- With `CPU_BUS_TIMEOUT_EN` and no ack on a read of `$6000`: request drops after 15 cycles, `data_o`=open bus, `data_valid_o`=1.
- Change `address_i` during RAM_READ, and separately during WAIT_TARGET: `data_valid_o` is never high for the new address with old data. The pending cart request holds until ack.
